// File: rtl/riscv_mem_pkg.sv
// Shared types for the core-to-RAM load/store path: access sizes, LSU FSM states, word width.
// Pure declarations; no latency or backpressure of its own.
package riscv_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_unit.sv
// Little-endian lane extract (loads) and lane merge (sub-word stores) on one RAM word.
// Purely combinational, zero latency, no flow control.
module lsu_lane_unit
  import riscv_mem_pkg::*;
(
  input  logic [1:0]        offset,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    case (offset)
      2'd0:    lane_b = old_word[7:0];
      2'd1:    lane_b = old_word[15:8];
      2'd2:    lane_b = old_word[23:16];
      default: lane_b = old_word[31:24];
    endcase
    lane_h = offset[1] ? old_word[31:16] : old_word[15:0];
  end

  always_comb begin
    load_data = old_word;
    case (size)
      SZ_B: load_data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H: load_data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = old_word;
    endcase
  end

  always_comb begin
    merged_word = old_word;
    case (size)
      SZ_B: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
      SZ_H: merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/ram_lsu_port.sv
// Byte/half/word load-store port onto a single-port word RAM; sub-word stores run as read-modify-write.
// Latency err 1, SW 2, load 3+LAT-1, sub-word store 4+LAT-1 cycles; one request in flight, req_ready low while busy.
module ram_lsu_port
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata
);

  localparam int CNT_W = 3;

  lsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_last;
  logic              accept;
  logic              req_err;
  logic              word_store;
  mem_size_e         req_sz;

  logic              r_we;
  mem_size_e         r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [WORD_W-1:0] r_wdata;

  logic [WORD_W-1:0] load_data;
  logic [WORD_W-1:0] merged_word;

  assign req_sz     = mem_size_e'(req_size);
  assign accept     = req_valid & req_ready;
  assign rd_last    = (rd_cnt == CNT_W'(RAM_RD_LAT));
  assign word_store = req_we & (req_sz == SZ_W);

  // Anything at or above the RAM's byte span is out of range.
  always_comb begin
    req_err = 1'b0;
    if (req_sz == SZ_RSV)                          req_err = 1'b1;
    if ((req_sz == SZ_H) && req_addr[0])           req_err = 1'b1;
    if ((req_sz == SZ_W) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (|req_addr[31:ADDR_W+2])                    req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WR;
          else                 state_nxt = RD;
        end
      end
      RD:      if (rd_last) state_nxt = r_we ? WR : RESP;
      WR:      state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the async-reset state, so ram_wr_en drops the instant rst falls.
  always_comb begin
    req_ready = rst & (state == IDLE);
    ram_wr_en = (state == WR);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt     <= '0;
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_wdata    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_we       <= req_we;
            r_size     <= req_sz;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            ram_addr   <= req_addr[ADDR_W+1:2];
            rd_cnt     <= '0;
            rsp_err    <= req_err;
            rsp_rdata  <= '0;
            if (word_store && !req_err) ram_wdata <= req_wdata;
          end
        end
        RD: begin
          if (rd_last) begin
            if (r_we) ram_wdata <= merged_word;
            else      rsp_rdata <= load_data;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lsu_lane_unit u_lane (
    .offset      (r_off),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .old_word    (ram_rdata),
    .store_data  (r_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

endmodule

// File: tb/tb_ram_lsu_port.sv
// Directed bench for ram_lsu_port against a one-cycle-latency word RAM model.
// Each scenario task drives requests and compares timing, RAM writes and responses inline.
module tb_ram_lsu_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_wr_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wdata;
    rd_q <= mem[ram_addr];
  end
  assign ram_rdata = rd_q;

  ram_lsu_port #(.ADDR_W(10), .RAM_RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .ram_wr_en    (ram_wr_en),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Issues one request and observes 8 cycles after accept (cycle T), sampling mid-cycle.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int rsp_cyc, output logic err, output logic [31:0] rdata,
                         output int wr_cnt, output int wr_cyc,
                         output logic [9:0] wr_addr, output logic [31:0] wr_data);
    rsp_cyc = -1; err = 1'bx; rdata = 'x;
    wr_cnt = 0; wr_cyc = -1; wr_addr = 'x; wr_data = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = k; err = rsp_err; rdata = rsp_rdata;
      end
      if (ram_wr_en) begin
        wr_cnt++;
        if (wr_cyc < 0) begin
          wr_cyc = k; wr_addr = ram_addr; wr_data = ram_wdata;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    n_cmp++; if (ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", ram_wr_en); end
    n_cmp++; if (ram_addr !== 10'd0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    n_cmp++; if (ram_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_word_store();
    int rc, wc, wy; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h104, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (wc !== 1 || wy !== 1) begin n_bad++; $display("FAIL sw_wr_timing got cnt=%0d cyc=%0d want cnt=1 cyc=1", wc, wy); end
    n_cmp++; if (wa !== 10'd5 || wd !== 32'h104) begin n_bad++; $display("FAIL sw_wr_word got addr=%0d data=%h want addr=5 data=00000104", wa, wd); end
    n_cmp++; if (rc !== 2 || e !== 1'b0) begin n_bad++; $display("FAIL sw_rsp got cyc=%0d err=%b want cyc=2 err=0", rc, e); end
  endtask

  task automatic test_word_load();
    int rc, wc, wy; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rc !== 3 || e !== 1'b0) begin n_bad++; $display("FAIL lw_rsp got cyc=%0d err=%b want cyc=3 err=0", rc, e); end
    n_cmp++; if (rd !== 32'h104) begin n_bad++; $display("FAIL lw_rdata got %h want 00000104", rd); end
    n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL lw_no_write got %0d writes want 0", wc); end
  endtask

  task automatic test_byte();
    int rc, wc, wy; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h11223344, rc, e, rd, wc, wy, wa, wd);
    run_req(1'b1, 2'd0, 1'b0, 32'h15, 32'hAB, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (wc !== 1 || wy !== 3) begin n_bad++; $display("FAIL sb_wr_timing got cnt=%0d cyc=%0d want cnt=1 cyc=3", wc, wy); end
    n_cmp++; if (wa !== 10'd5 || wd !== 32'h1122AB44) begin n_bad++; $display("FAIL sb_merge got addr=%0d data=%h want addr=5 data=1122ab44", wa, wd); end
    n_cmp++; if (rc !== 4 || e !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sb_rsp got cyc=%0d err=%b rdata=%h want cyc=4 err=0 rdata=0", rc, e, rd); end
    run_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'hFFFFFFAB || rc !== 3) begin n_bad++; $display("FAIL lb_sext got %h cyc=%0d want ffffffab cyc=3", rd, rc); end
    run_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'h000000AB) begin n_bad++; $display("FAIL lbu_zext got %h want 000000ab", rd); end
  endtask

  task automatic test_half();
    int rc, wc, wy; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'h80001234, rc, e, rd, wc, wy, wa, wd);
    run_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'hFFFF8000) begin n_bad++; $display("FAIL lh_sext got %h want ffff8000", rd); end
    run_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'h00008000) begin n_bad++; $display("FAIL lhu_zext got %h want 00008000", rd); end
    run_req(1'b1, 2'd1, 1'b0, 32'h14, 32'hBEEF, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (wd !== 32'h8000BEEF || wy !== 3) begin n_bad++; $display("FAIL sh_merge got %h cyc=%0d want 8000beef cyc=3", wd, wy); end
    run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'h8000BEEF) begin n_bad++; $display("FAIL sh_readback got %h want 8000beef", rd); end
  endtask

  task automatic test_errors();
    logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  t_sz   [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    logic [31:0] t_addr [4] = '{32'h16, 32'h15, 32'h1000, 32'h14};
    int rc, wc, wy; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    for (int i = 0; i < 4; i++) begin
      run_req(t_we[i], t_sz[i], 1'b0, t_addr[i], 32'hDEADBEEF, rc, e, rd, wc, wy, wa, wd);
      n_cmp++;
      if (rc !== 1 || e !== 1'b1 || rd !== 32'h0 || wc !== 0) begin
        n_bad++;
        $display("FAIL err_case%0d got cyc=%0d err=%b rdata=%h writes=%0d want cyc=1 err=1 rdata=0 writes=0", i, rc, e, rd, wc);
      end
    end
  endtask

  task automatic test_reset_abort();
    int rc, wc, wy, bad_wr, bad_rsp; logic e; logic [31:0] rd, wd; logic [9:0] wa;
    bad_wr = 0; bad_rsp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ram_wr_en) bad_wr++;
      if (rsp_valid) bad_rsp++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready_after_release got %b want 1", req_ready); end
    for (int k = 0; k < 5; k++) begin
      if (ram_wr_en) bad_wr++;
      if (rsp_valid) bad_rsp++;
      @(negedge clk);
    end
    n_cmp++; if (bad_wr !== 0) begin n_bad++; $display("FAIL abort_no_write got %0d write cycles want 0", bad_wr); end
    n_cmp++; if (bad_rsp !== 0) begin n_bad++; $display("FAIL abort_no_rsp got %0d rsp cycles want 0", bad_rsp); end
    run_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rc, e, rd, wc, wy, wa, wd);
    n_cmp++; if (rd !== 32'h8000BEEF) begin n_bad++; $display("FAIL abort_word_intact got %h want 8000beef", rd); end
  endtask

  task automatic test_back_to_back();
    int n_wr, n_rsp;
    logic [9:0] wr_pos;
    n_wr = 0; n_rsp = 0; wr_pos = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFE0001;
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      if (ram_wr_en) begin n_wr++; wr_pos[k] = 1'b1; end
      if (rsp_valid) n_rsp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (n_wr !== 3 || wr_pos !== 10'b0010010010) begin n_bad++; $display("FAIL b2b_wr_pattern got cnt=%0d pos=%b want cnt=3 pos=0010010010", n_wr, wr_pos); end
    n_cmp++; if (n_rsp !== 3) begin n_bad++; $display("FAIL b2b_rsp_count got %0d want 3", n_rsp); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_byte();
    test_half();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
